wide_add_seq: RTL and testbench
===============================

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 SHALL have parameter NWORDS, default 4, giving the number of 32-bit words per operand (legal range 2..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand request is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a request.
REQ-006 SHALL have port in_a, input, 32*NWORDS bits: operand A, with word 0 = bits [31:0].
REQ-007 SHALL have port in_b, input, 32*NWORDS bits: operand B.
REQ-008 SHALL have port in_sub, input, 1 bit: 1 selects A-B, 0 selects A+B.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port out_sum, output, 32*NWORDS bits: the result.
REQ-012 SHALL have port out_cout, output, 1 bit: carry out of the MSB (for subtraction, 1 means no borrow).
REQ-013 SHALL have port out_ovf, output, 1 bit: signed overflow.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-016 IDLE: on in_valid&in_ready, SHALL register in_a, in_b and in_sub, set word index 0 and carry register to in_sub, then go to RUN.
REQ-017 RUN: each cycle SHALL send word[idx] of A, word[idx] of B XOR {32{sub}}, and the carry register to one shared 32-bit CLA.
REQ-018 In the same RUN cycle, the CLA sum SHALL be written into result word idx, the carry register updated and idx incremented.
REQ-019 Word carry-out SHALL be a31&b31 | (a31^b31)&c31, where c31 = a31^b31^s31; a, b and s are the CLA inputs and output.
REQ-020 When idx = NWORDS-1, the last RUN cycle SHALL go to DONE and set out_cout to the final carry.
REQ-021 The same last RUN cycle SHALL set out_ovf = c31 ^ carry-out of that word.
REQ-022 Latency SHALL be fixed: accept at edge T, out_valid high after edge T+NWORDS, independent of operand values.
REQ-023 DONE: out_sum, out_cout and out_ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 DONE: on out_ready SHALL return to IDLE; in_ready rises the next cycle, with no same-cycle accept (no overlap).
REQ-025 in_valid in RUN or DONE SHALL be ignored; no request is lost or merged, because the producer holds it until in_ready.
REQ-026 Operand inputs SHALL NOT affect an operation after capture.
REQ-027 The sum SHALL wrap modulo 2^(32*NWORDS); wrap is reported only via out_cout and out_ovf.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, idx 0, carry 0, out_sum 0, out_cout 0, out_ovf 0, out_valid 0 and in_ready 1, even mid-RUN or mid-DONE.
REQ-029 An operation interrupted by reset SHALL be discarded; after rst_n rises, the first accepted request behaves per REQ-022.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE/RUN/DONE), the WORD_W=32 constant and the word-carry function of REQ-019.
REQ-031 The single sub-module SHALL be one instance of the team's existing 32-bit carry-lookahead adder cla (ports a, b, cin, sum).
REQ-032 Word select and result write SHALL be indexed muxing on idx; there SHALL be no per-word adder replication.

Verification
REQ-033 NWORDS=4, A=2^32-1, B=1, add: out_sum=2^32, cout=0, ovf=0, out_valid exactly 4 cycles after accept.
REQ-034 A=all ones, B=1, add: out_sum=0, cout=1, ovf=0 (full wrap-around through all words).
REQ-035 A=0x7FFF..FF, B=1, add: out_sum=0x8000..00, ovf=1, cout=0; then A=5, B=7, sub: out_sum=-2 (all ones except bit0=0), cout=0.
REQ-036 out_ready held low 10 cycles in DONE: outputs stable and in_ready=0 throughout; the in_valid pulse during that time is not accepted.
REQ-037 rst_n asserted in the 2nd RUN cycle: all outputs go to reset values without a clock edge; the next request A=3, B=4 gives 7 with nominal latency.
REQ-038 Random test of 1000 add/sub operands with random out_ready backpressure: results match a 128-bit reference model; exactly one result per accept.

Source files
------------

// File: rtl/wide_add_seq_pkg.sv
// Shared types and helpers for the word-serial wide adder: FSM states, word width, word carry-out.
// No logic of its own; imported by wide_add_seq.
package wide_add_seq_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Carry out of a word, rebuilt from the MSB inputs and sum bit so the CLA needs no cout port.
  function automatic logic word_carry(input logic a31, input logic b31, input logic s31);
    logic c31;
    c31 = a31 ^ b31 ^ s31;
    return (a31 & b31) | ((a31 ^ b31) & c31);
  endfunction

endpackage

// File: rtl/cla.sv
// 32-bit carry-lookahead adder built from 4-bit lookahead groups chained on group carry.
// Purely combinational, zero latency; no flow control.
module cla (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic        unused_cout;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    int k;
    k    = 0;
    c    = '0;
    c[0] = cin;
    for (int grp = 0; grp < 8; grp++) begin
      k        = 4 * grp;
      c[k + 1] = g[k] | (p[k] & c[k]);
      c[k + 2] = g[k + 1] | (p[k + 1] & g[k]) | (p[k + 1] & p[k] & c[k]);
      c[k + 3] = g[k + 2] | (p[k + 2] & g[k + 1]) | (p[k + 2] & p[k + 1] & g[k])
               | (p[k + 2] & p[k + 1] & p[k] & c[k]);
      c[k + 4] = g[k + 3] | (p[k + 3] & g[k + 2]) | (p[k + 3] & p[k + 2] & g[k + 1])
               | (p[k + 3] & p[k + 2] & p[k + 1] & g[k])
               | (p[k + 3] & p[k + 2] & p[k + 1] & p[k] & c[k]);
    end
  end

  assign sum         = p ^ c[31:0];
  assign unused_cout = c[32];

endmodule

// File: rtl/wide_add_seq.sv
// Word-serial NWORDS x 32-bit add/sub through one shared CLA; latency NWORDS cycles accept-to-valid.
// One operation in flight: in_ready only in IDLE, result held in DONE until out_ready.
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W*NWORDS-1:0] in_a,
  input  logic [WORD_W*NWORDS-1:0] in_b,
  input  logic                     in_sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W*NWORDS-1:0] out_sum,
  output logic                     out_cout,
  output logic                     out_ovf
);

  localparam int IDX_W = $clog2(NWORDS);

  typedef logic [NWORDS-1:0][WORD_W-1:0] opnd_t;

  state_t            state;
  state_t            state_nxt;
  opnd_t             a_q;
  opnd_t             b_q;
  opnd_t             sum_q;
  logic              sub_q;
  logic              carry_q;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] cla_a;
  logic [WORD_W-1:0] cla_b;
  logic [WORD_W-1:0] cla_sum;
  logic              word_cout;
  logic              c31;
  logic              last_word;

  // Subtraction is A + ~B + 1: B inverted here, the +1 comes from carry_q seeded with in_sub.
  assign cla_a     = a_q[idx];
  assign cla_b     = b_q[idx] ^ {WORD_W{sub_q}};
  assign last_word = (idx == IDX_W'(NWORDS - 1));

  cla u_cla (
    .a   (cla_a),
    .b   (cla_b),
    .cin (carry_q),
    .sum (cla_sum)
  );

  assign c31       = cla_a[WORD_W-1] ^ cla_b[WORD_W-1] ^ cla_sum[WORD_W-1];
  assign word_cout = word_carry(cla_a[WORD_W-1], cla_b[WORD_W-1], cla_sum[WORD_W-1]);
  assign out_sum   = sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_word) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx      <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            sub_q   <= in_sub;
            carry_q <= in_sub;
            idx     <= '0;
          end
        end
        RUN: begin
          sum_q[idx] <= cla_sum;
          carry_q    <= word_cout;
          if (last_word) begin
            idx      <= '0;
            out_cout <= word_cout;
            out_ovf  <= c31 ^ word_cout;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed + random bench for wide_add_seq with an expected-result queue checked on each output handshake.
module tb_wide_add_seq;

  localparam int NW = 4;
  localparam int W  = 32 * NW;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a      = '0;
  logic [W-1:0] in_b      = '0;
  logic         in_sub    = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  exp_t         sb_q[$];
  int           n_cmp    = 0;
  int           n_bad    = 0;
  int           n_acc    = 0;
  int           n_res    = 0;
  int           n_disc   = 0;
  int           cyc      = 0;
  int           acc_edge = 0;
  logic         prev_vld = 1'b0;
  logic         bp_on    = 1'b0;

  logic [W-1:0] ta;
  logic [W-1:0] tb;
  logic         ts;
  exp_t         te;
  int           wait_n;
  int           acc0;

  wide_add_seq #(.NWORDS(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.ovf  = o;
    return e;
  endfunction

  // Reference: full-width integer add with the signed-overflow rule taken from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W:0]   r;
    logic [W-1:0] bb;
    exp_t         e;
    bb     = s ? ~b : b;
    r      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
    e.sum  = r[W-1:0];
    e.cout = r[W];
    if (s) e.ovf = (a[W-1] != b[W-1]) && (e.sum[W-1] != a[W-1]);
    else   e.ovf = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
    return e;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NW; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
    int n;
    n        = 0;
    in_a     = a;
    in_b     = b;
    in_sub   = s;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = rand_w();
    in_b     = rand_w();
    in_sub   = ~s;
    if (n < 200) sb_q.push_back(e);
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb_q.size(), 0);
  endtask

  // Monitor: counts accepts, checks latency and pops the expected queue on each result handshake.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        n_acc++;
        acc_edge = cyc + 1;
      end
      if (out_valid && !prev_vld) check("latency", cyc - acc_edge, NW);
      if (out_valid && out_ready) begin
        n_res++;
        check("sb_depth", sb_q.size(), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("sum", out_sum, e.sum);
          check("cout", out_cout, e.cout);
          check("ovf", out_ovf, e.ovf);
        end
      end
    end
    prev_vld = out_valid;
  end

  initial begin
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cout", out_cout, 0);
    check("rst_out_ovf", out_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Carry from word 0 into word 1.
    send(128'hFFFF_FFFF, 128'h1, 1'b0, mk(128'h1_0000_0000, 1'b0, 1'b0));
    wait_drain(50);
    // Carry ripples through every word and out of the MSB.
    ta = '1;
    send(ta, 128'h1, 1'b0, mk('0, 1'b1, 1'b0));
    wait_drain(50);
    // Positive + positive overflowing into the sign bit.
    ta = {1'b0, {(W-1){1'b1}}};
    tb = {1'b1, {(W-1){1'b0}}};
    send(ta, 128'h1, 1'b0, mk(tb, 1'b0, 1'b1));
    wait_drain(50);

    // Reset during the second RUN cycle discards the operation.
    @(negedge clk);
    in_a     = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    in_b     = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    in_sub   = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_disc++;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_sum", out_sum, 0);
    check("mid_rst_out_cout", out_cout, 0);
    check("mid_rst_out_ovf", out_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(128'h3, 128'h4, 1'b0, mk(128'h7, 1'b0, 1'b0));
    wait_drain(50);

    // 5 - 7 = -2 with a borrow.
    tb = {{(W-1){1'b1}}, 1'b0};
    send(128'h5, 128'h7, 1'b1, mk(tb, 1'b0, 1'b0));
    wait_drain(50);

    // Hold the result for 10 cycles with a stray request in the middle.
    ta = rand_w();
    tb = rand_w();
    te = model(ta, tb, 1'b1);
    out_ready = 1'b0;
    send(ta, tb, 1'b1, te);
    wait_n = 0;
    while (!out_valid && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check("stall_reach_done", out_valid, 1);
    acc0 = n_acc;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i == 3);
      if (i == 3) in_a = rand_w();
      #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_sum", out_sum, te.sum);
      check("stall_out_cout", out_cout, te.cout);
      check("stall_out_ovf", out_ovf, te.ovf);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    check("stall_req_ignored", n_acc, acc0);
    check("stall_drained", sb_q.size(), 0);

    // Random operands with random consumer backpressure.
    @(negedge clk);
    bp_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          ts = 1'($urandom_range(0, 1));
          ta = rand_w();
          tb = rand_w();
          case ($urandom_range(0, 7))
            0: tb = ts ? ta : ~ta;
            1: ta = '1;
            default: ;
          endcase
          send(ta, tb, ts, model(ta, tb, ts));
        end
        wait_drain(2000);
        bp_on = 1'b0;
      end
      begin
        while (bp_on) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    check("result_count", n_res, n_acc - n_disc);
    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
